// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser states, frame geometry and default bit timing.
package uart_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO, depth 2**AW; pointers wrap and a separate count keeps full/empty exact.
module uart_tx_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  wdata,
  input  logic        pop,
  output logic [7:0]  rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [7:0]    mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == {1'b1, {AW{1'b0}}});
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // Full blocks a push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// FIFO-buffered UART transmitter, 8N1 by default; define UART_TX_PARITY_EN for an
// even-parity bit between data and stop (8E1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             txd,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_count
);

  localparam logic [15:0] BitLast = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  IdxLast = 3'(DATA_BITS - 1);

  tx_state_e            state_q;
  logic [15:0]          baud_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 txd_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [7:0] fifo_rdata;
  logic       bit_end;

  uart_tx_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid && tx_ready),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_end  = (baud_q == '0);
  // Pop when idle, or at the end of a stop bit so the next frame follows with no gap.
  assign fifo_pop = !fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && bit_end));
  assign tx_ready = !fifo_full;
  assign busy     = (state_q != StIdle) || !fifo_empty;
  assign txd      = txd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (fifo_pop) begin
      shift_q  <= fifo_rdata;
      txd_q    <= 1'b0;
      baud_q   <= BitLast;
      state_q  <= StStart;
`ifdef UART_TX_PARITY_EN
      parity_q <= ^fifo_rdata;
`endif
    end else if (state_q != StIdle) begin
      if (!bit_end) begin
        baud_q <= baud_q - 16'd1;
      end else begin
        baud_q <= BitLast;
        unique case (state_q)
          StStart: begin
            txd_q   <= shift_q[0];
            idx_q   <= '0;
            state_q <= StData;
          end
          StData: begin
            if (idx_q == IdxLast) begin
`ifdef UART_TX_PARITY_EN
              txd_q   <= parity_q;
              state_q <= StParity;
`else
              txd_q   <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
              idx_q   <= idx_q + 3'd1;
            end
          end
`ifdef UART_TX_PARITY_EN
          StParity: begin
            txd_q   <= 1'b1;
            state_q <= StStop;
          end
`endif
          StStop: begin
            // Reached only with an empty FIFO; a non-empty one is popped above.
            baud_q  <= '0;
            state_q <= StIdle;
          end
          default: begin
            txd_q   <= 1'b1;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed steps with a frame-decoding scoreboard.
module tb_uart_tx;

  localparam int C  = 4;
  localparam int AW = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          txd;
  logic          busy;
  logic [AW:0]   fifo_count;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            t0;
  logic [7:0]    sb[$];

  logic          mon_active = 1'b0;
  int            mon_cnt = 0;
  int            mon_bit;
  logic [7:0]    mon_byte = '0;

  uart_tx #(
    .CLKS_PER_BIT (C),
    .FIFO_AW      (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 5000) begin
      tick();
      n++;
    end
    check("ready_timeout", tx_ready, 1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    wait_ready();
    tick();
    sb.push_back(b);
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 5000) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
    check({tag, "_sb"}, sb.size(), 0);
  endtask

  // Frame decoder: samples each bit mid-cell on the falling edge.
  assign mon_bit = mon_cnt / C;

  always @(negedge clk) begin
    if (rst) begin
      mon_active <= 1'b0;
    end else if (!mon_active) begin
      if (txd === 1'b0) begin
        mon_active <= 1'b1;
        mon_cnt    <= 1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt == NBITS * C - 1) mon_active <= 1'b0;
      if (mon_cnt % C == C / 2) begin
        if (mon_bit == 0) begin
          check("mon_start", txd, 0);
        end else if (mon_bit <= 8) begin
          mon_byte <= {txd, mon_byte[7:1]};
`ifdef UART_TX_PARITY_EN
        end else if (mon_bit == 9) begin
          check("mon_parity", txd, ^mon_byte);
`endif
        end else begin
          check("mon_stop", txd, 1);
          check("mon_expected", sb.size() != 0, 1);
          if (sb.size() != 0) check("mon_data", mon_byte, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) tick();
    check("rst_txd", txd, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    rst = 1'b0;
    tick();

    // Single byte: exact waveform and latency
    push_byte(8'h55);
    t0 = cyc;
    tx_valid = 1'b0;
    check("t1_count", fifo_count, 1);
    check("t1_txd_before", txd, 1);
    check("t1_busy", busy, 1);
    tick();
    check("t1_popped", fifo_count, 0);
    for (int i = 0; i < NBITS * C; i++) begin
      check("t1_txd", txd, frame_bit(8'h55, i / C));
      if (i == NBITS * C - 1) check("t1_busy_last", busy, 1);
      tick();
    end
    check("t1_busy_fall", busy, 0);
    check("t1_txd_idle", txd, 1);
    wait_idle("t1_idle");

    // Back-to-back frames with no idle gap
    push_byte(8'hA3);
    t0 = cyc;
    push_byte(8'h00);
    push_byte(8'hFF);
    tx_valid = 1'b0;
    wait_idle("t2_idle");
    check("t2_length", cyc - t0, 1 + 3 * NBITS * C);

    // Fill to full, then hold valid through a pop
    for (int b = 0; b < 5; b++) push_byte(8'(b));
    check("t3_full_count", fifo_count, 4);
    check("t3_full_ready", tx_ready, 0);
    tx_data = 8'd5;
    wait_ready();
    check("t3_pop_reject", fifo_count, 3);
    tick();
    sb.push_back(8'd5);
    push_byte(8'd6);
    push_byte(8'd7);
    tx_valid = 1'b0;
    wait_idle("t3_idle");

    // Reset in the third data bit with two bytes queued
    push_byte(8'h0F);
    t0 = cyc;
    push_byte(8'h11);
    push_byte(8'h22);
    tx_valid = 1'b0;
    wait_cyc(t0 + 1 + 3 * C + 1);
    check("t4_bit2", txd, 1);
    check("t4_queued", fifo_count, 2);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    check("t4_txd", txd, 1);
    check("t4_count", fifo_count, 0);
    check("t4_busy", busy, 0);
    check("t4_ready", tx_ready, 1);
    ok = 1'b1;
    repeat (3 * NBITS * C) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    check("t4_line_idle", ok, 1);

    // Push and pop on the same edge at count 2
    push_byte(8'hA1);
    t0 = cyc;
    push_byte(8'hB2);
    push_byte(8'hC3);
    tx_valid = 1'b0;
    wait_cyc(t0 + NBITS * C);
    check("t5_count_pre", fifo_count, 2);
    tx_data  = 8'hD4;
    tx_valid = 1'b1;
    tick();
    sb.push_back(8'hD4);
    tx_valid = 1'b0;
    check("t5_count_post", fifo_count, 2);
    check("t5_restart", txd, 0);
    wait_idle("t5_idle");

`ifdef UART_TX_PARITY_EN
    push_byte(8'h07);
    t0 = cyc;
    tx_valid = 1'b0;
    wait_cyc(t0 + 1 + 9 * C + 1);
    check("par_07", txd, 1);
    wait_idle("par_07_idle");
    check("par_length", cyc - t0, 1 + 44);
    push_byte(8'h03);
    t0 = cyc;
    tx_valid = 1'b0;
    wait_cyc(t0 + 1 + 9 * C + 1);
    check("par_03", txd, 0);
    wait_idle("par_03_idle");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the outbound counterpart of the core's serial receive path on `rxd`.
- Accepts bytes from the core over a valid/ready handshake and buffers them in a small synchronous FIFO.
- Serialises each byte onto `txd` as 8N1 (start, 8 data bits LSB-first, stop).
- Sits inside the core's clock domain; `txd` leaves the chip directly.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200 baud); legal range 2..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
- clk  in  1  core clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid this cycle.
- tx_ready  out  1  FIFO can accept; a byte is pushed when tx_valid && tx_ready.
- txd  out  1  serial line, idle high; driven from a flop.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  out  FIFO_AW+1  number of bytes queued (excludes the byte in the shifter).

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: txd=1, tx_ready=1, busy=0, fifo_count=0, FSM=IDLE, baud counter=0, FIFO pointers=0.
- Handshake:
  - tx_ready = (fifo_count != depth), combinational from registered count.
  - tx_valid while tx_ready=0 is ignored; the producer must hold the byte.
  - No bypass: a byte always passes through the FIFO.
- Push and pop:
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Full FIFO: tx_ready=0, so no push, even if a pop occurs that cycle.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if FIFO non-empty, pop the head into the shift register, txd<=0, baud counter<=CLKS_PER_BIT-1, go to START.
  - START/DATA/STOP: each bit holds for exactly CLKS_PER_BIT cycles; the counter decrements and the bit ends when it reaches 0.
  - START -> DATA: txd<=shift[0], bit index<=0.
  - DATA: at each bit end, shift right, txd<=next bit, index++; after bit 7, txd<=1 and go to STOP.
  - STOP end with FIFO non-empty: pop and go to START in the same cycle (back-to-back frames, no idle gap).
  - STOP end with FIFO empty: go to IDLE.
- Latency: byte accepted at edge N into an empty FIFO in IDLE → txd low after edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles. k back-to-back bytes occupy 10*k*CLKS_PER_BIT cycles.
- busy = (state != IDLE) || (fifo_count != 0).
- FIFO pointers are FIFO_AW bits and wrap modulo depth; count is tracked separately, so full and empty are unambiguous.
- Reset mid-frame: next edge forces txd=1, discards FIFO contents and the partial frame, FSM=IDLE. The truncated frame is not resumed.
- rst has priority over push/pop in the same cycle.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: adds state PARITY between DATA and STOP. It transmits the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT cycles (8E1).
- Undefined: no PARITY state, no parity logic; frame is 8N1 as above.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS=8;
  - default CLKS_PER_BIT constant.
- One sub-module, uart_tx_fifo: synchronous FIFO, parameter AW, with push/pop/full/empty/count. It can be reused by the receive path.
- Serialiser FSM and baud counter stay in uart_tx.

Test Plan:
- CLKS_PER_BIT=4, push 0x55 once → txd low from edge N+1 for 4 cycles; then 1,0,1,0,1,0,1,0 at 4 cycles each; then high 4 cycles; busy falls at edge N+41.
- Push 0xA3,0x00,0xFF on consecutive cycles → three frames contiguous, 120 cycles total; no idle high gap between a stop bit and the next start bit.
- FIFO_AW=2, hold tx_valid=1 with data 0..7 → tx_ready drops once fifo_count=4 plus one byte in the shifter. Every byte is transmitted exactly once, in order, with none lost or duplicated.
- Assert rst at the 3rd data bit of 0x0F with 2 bytes queued → txd=1, fifo_count=0, busy=0 after one edge; line stays idle afterwards.
- With UART_TX_PARITY_EN, send 0x07 → parity bit 1, frame 44 cycles. Send 0x03 → parity bit 0.
- Push and pop in the same cycle at fifo_count=2 → fifo_count stays 2; full FIFO with tx_valid=1 during a pop → push rejected, count drops to depth-1.
